// File: rtl/full_adder_pkg.sv
// Purpose : shared constants for the ripple-carry full-adder datapath.
// Latency : n/a (constants only).
// Backpressure: n/a.
// Contents: FA_WIDTH_DEFAULT (default operand width), FA_WIDTH_MAX (widest legal operand).
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// Purpose : one-bit gate-level full-adder cell, the building block of the ripple chain.
// Latency : purely combinational, no state.
// Backpressure: none.
// Ports   : x, y  - operand bits; ci - carry in; s - sum bit; co - carry out.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term is shared by the sum and the carry-out.
  logic w_p;

  assign w_p = x ^ y;
  assign s   = w_p ^ ci;
  assign co  = (x & y) | (ci & w_p);

endmodule : full_adder_cell

// File: rtl/full_adder_struct.sv
// Purpose : WIDTH-bit unsigned adder {cout, sum} = a + b + c built as a ripple chain of full_adder_cell.
// Latency : 1 cycle, result and out_valid registered on the edge that samples in_valid.
// Backpressure: none, one result per cycle, never stalls.
// Ports   : clk, rst_n (async active-low); in_valid, a, b, c (operands); sum, cout, out_valid (registered result);
//           ovf (registered two's-complement overflow) exists only when FULL_ADDER_STRUCT_OVF_EN is defined.
// WIDTH legal range is 1..FA_WIDTH_MAX.
module full_adder_struct
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_STRUCT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // w_carry[i] is the carry into cell i; w_carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .x  (a[i]),
      .y  (b[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_vld;

  // Result registers only load on a valid cycle so they hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_vld;

`ifdef FULL_ADDER_STRUCT_OVF_EN
  // Signed overflow: carries into and out of the MSB cell disagree.
  // For WIDTH=1 the carry into the MSB is c itself, giving cout ^ c.
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : full_adder_struct

// File: tb/tb_full_adder_struct.sv
// Purpose : scoreboard bench for full_adder_struct at WIDTH = 1, 8 and 16.
// Latency : stimulus pushes the expected result when it drives; monitors pop one cycle later.
// Backpressure: none exercised, the DUT has none.
module tb_full_adder_struct;

  typedef struct packed {
    logic        vld;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic        i1_vld = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic        o1_sum, o1_cout, o1_vld, o1_ovf;
  // WIDTH = 8 instance
  logic        i8_vld = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  o8_sum;
  logic        o8_cout, o8_vld, o8_ovf;
  // WIDTH = 16 instance
  logic        i16_vld = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] o16_sum;
  logic        o16_cout, o16_vld, o16_ovf;

  full_adder_struct #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i1_vld), .a(a1), .b(b1), .c(c1),
    .sum(o1_sum), .cout(o1_cout), .out_valid(o1_vld)
`ifdef FULL_ADDER_STRUCT_OVF_EN
    , .ovf(o1_ovf)
`endif
  );

  full_adder_struct #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(i8_vld), .a(a8), .b(b8), .c(c8),
    .sum(o8_sum), .cout(o8_cout), .out_valid(o8_vld)
`ifdef FULL_ADDER_STRUCT_OVF_EN
    , .ovf(o8_ovf)
`endif
  );

  full_adder_struct #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(i16_vld), .a(a16), .b(b16), .c(c16),
    .sum(o16_sum), .cout(o16_cout), .out_valid(o16_vld)
`ifdef FULL_ADDER_STRUCT_OVF_EN
    , .ovf(o16_ovf)
`endif
  );

`ifndef FULL_ADDER_STRUCT_OVF_EN
  assign o1_ovf  = 1'b0;
  assign o8_ovf  = 1'b0;
  assign o16_ovf = 1'b0;
`endif

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];
  exp_t last_e [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input exp_t e, input logic vld, input logic [63:0] s,
                     input logic co, input logic ov);
    n_vec++;
    if (vld !== e.vld || s !== e.sum || co !== e.cout
`ifdef FULL_ADDER_STRUCT_OVF_EN
        || ov !== e.ovf
`endif
       ) begin
      n_err++;
      $display("FAIL %s: got vld=%0b sum=%h cout=%0b ovf=%0b, expected vld=%0b sum=%h cout=%0b ovf=%0b",
               nm, vld, s, co, ov, e.vld, e.sum, e.cout, e.ovf);
    end
  endtask

  task automatic spur(input string nm);
    n_err++;
    $display("FAIL %s: out_valid=1 with no result expected", nm);
  endtask

  task automatic chk_zero(input string nm, input logic vld, input logic [63:0] s,
                          input logic co, input logic ov);
    n_vec++;
    if (vld !== 1'b0 || s !== 64'd0 || co !== 1'b0 || ov !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got vld=%0b sum=%h cout=%0b ovf=%0b, expected all zero", nm, vld, s, co, ov);
    end
  endtask

  // Monitor: sample just after each rising edge and compare against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) cmp("w1", q1.pop_front(), o1_vld, 64'(o1_sum), o1_cout, o1_ovf);
    else if (o1_vld) spur("w1");
    if (q8.size() > 0) cmp("w8", q8.pop_front(), o8_vld, 64'(o8_sum), o8_cout, o8_ovf);
    else if (o8_vld) spur("w8");
    if (q16.size() > 0) cmp("w16", q16.pop_front(), o16_vld, 64'(o16_sum), o16_cout, o16_ovf);
    else if (o16_vld) spur("w16");
  end

  // Drive one cycle on instance w (0: W1, 1: W8, 2: W16) and push what that cycle must produce.
  // An idle cycle expects out_valid=0 with the previous result held.
  task automatic step(input int w, input bit v, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic [63:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    if (v) begin
      e = '{1'b1, es, ec, eo};
      last_e[w] = e;
    end else begin
      e = last_e[w];
      e.vld = 1'b0;
    end
    case (w)
      0: begin i1_vld = v; a1 = a[0]; b1 = b[0]; c1 = c; q1.push_back(e); end
      1: begin i8_vld = v; a8 = a[7:0]; b8 = b[7:0]; c8 = c; q8.push_back(e); end
      default: begin i16_vld = v; a16 = a[15:0]; b16 = b[15:0]; c16 = c; q16.push_back(e); end
    endcase
  endtask

  task automatic idle(input int w);
    step(w, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  // WIDTH=1 truth table {cout,sum} for (a,b,c) = 000..111; overflow set for 001 and 110.
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [7:0] tov = 8'b0100_0010;

  initial begin
    for (int k = 0; k < 3; k++) last_e[k] = '0;

    // Reset asserted between edges: outputs must be zero before any edge.
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_w1",  o1_vld,  64'(o1_sum),  o1_cout,  o1_ovf);
    chk_zero("rst_w8",  o8_vld,  64'(o8_sum),  o8_cout,  o8_ovf);
    chk_zero("rst_w16", o16_vld, 64'(o16_sum), o16_cout, o16_ovf);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(0, 1'b1, 64'(v[2]), 64'(v[1]), v[0], 64'(tt[i][0]), tt[i][1], tov[i]);
    end
    idle(0);

    // Wrap-around, all-ones boundary and overflow at WIDTH=8.
    step(1, 1'b1, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0);
    step(1, 1'b1, 64'hFF, 64'hFF, 1'b1, 64'hFF, 1'b1, 1'b0);
    step(1, 1'b1, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1);
    step(1, 1'b1, 64'h80, 64'h80, 1'b0, 64'h00, 1'b1, 1'b1);
    // Valid gating 1,0,1 with hold during the idle cycle.
    step(1, 1'b1, 64'h12, 64'h34, 1'b1, 64'h47, 1'b0, 1'b0);
    idle(1);
    step(1, 1'b1, 64'h55, 64'hAA, 1'b0, 64'hFF, 1'b0, 1'b0);
    idle(1);

    // WIDTH=16 all-ones boundary.
    step(2, 1'b1, 64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1, 1'b0);
    idle(2);

    // Reset mid-stream while out_valid=1, with in_valid still high across the reset edge.
    step(2, 1'b1, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_zero("midrst_w16", o16_vld, 64'(o16_sum), o16_cout, o16_ovf);
    chk_zero("midrst_w8",  o8_vld,  64'(o8_sum),  o8_cout,  o8_ovf);
    @(posedge clk);
    @(negedge clk);
    i16_vld = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) last_e[k] = '0;
    @(negedge clk);
    // Held value after reset must be zero, then the first post-reset operation.
    step(2, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(2, 1'b1, 64'h8000, 64'h8000, 1'b1, 64'h0001, 1'b1, 1'b1);

    // 100 random back-to-back operations at WIDTH=16.
    for (int n = 0; n < 100; n++) begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] r;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      r  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      step(2, 1'b1, 64'(ra), 64'(rb), rc, 64'(r[15:0]), r[16],
           (ra[15] == rb[15]) && (r[15] != ra[15]));
    end
    idle(2);

    repeat (4) @(posedge clk);
    #2;
    if (q1.size() + q8.size() + q16.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never checked, expected 0", q1.size() + q8.size() + q16.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder_struct
